// File: rtl/render_lock_arbiter_pkg.sv
// Shared types, mode constants and helpers for the render lock arbiter.
package render_arb_pkg;

  localparam int ARB_MODE_FIXED = 0;
  localparam int ARB_MODE_RR    = 1;

  // Widest supported requester vector; onehot_to_idx is sized for it.
  localparam int ARB_MAX_N = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  // Binary index of the set bit in a one-hot vector (0 for an all-zero vector).
  function automatic logic [4:0] onehot_to_idx(input logic [ARB_MAX_N-1:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < ARB_MAX_N; i++) begin
      if (oh[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/render_lock_arbiter_if.sv
// Request/grant bundle between render units (master) and the arbiter (slave).
interface render_lock_arbiter_if #(
  parameter int N = 6
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N-1:0]   done;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_idx;
  logic           timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_valid,
    input  gnt_idx,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_valid,
    output gnt_idx,
    output timeout
  );

endinterface

// File: rtl/render_lock_arbiter_picker.sv
// Combinational rotating MSB-first picker: scans downward from 'start',
// wrapping from 0 to N-1, and returns the first set bit as a one-hot vector.
module rotating_msb_picker #(
  parameter int N   = 6,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   vec,
  input  logic [IDW-1:0] start,
  output logic [N-1:0]   win,
  output logic           found
);

  logic [IDW-1:0] pos;

  // Walk start, start-1, ..., 0, N-1, ..., start+1 and keep the first hit.
  always_comb begin
    win   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = IDW'((int'(start) + N - int'(i)) % N);
      if (!found && vec[pos]) begin
        win[pos] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/render_lock_arbiter.sv
// Lockable N-way arbiter for shared render resources. A registered grant is
// held until the owner signals done, drops its request, or the hold limit is
// reached; selection is fixed MSB-first or round-robin.
module render_lock_arbiter
  import render_arb_pkg::*;
#(
  parameter int N        = 6,
  parameter int MODE     = ARB_MODE_FIXED,
  parameter int HOLD_MAX = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  render_lock_arbiter_if.slave  bus
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int HCW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

  arb_state_t     state_q, state_n;
  logic [HCW-1:0] hold_q, hold_n;
  logic [IDW-1:0] rr_last_q, rr_last_n;

  logic [N-1:0]   gnt_n;
  logic           valid_n;
  logic [IDW-1:0] idx_n;
  logic           timeout_n;

  logic           own_req;
  logic           own_done;
  logic           hold_hit;
  logic           rel;
  logic [N-1:0]   elig;
  logic [N-1:0]   win;
  logic           found;
  logic [IDW-1:0] start;

  // Owner status, release decision and the search origin for the picker.
  always_comb begin
    own_req  = |(bus.req & bus.gnt);
    own_done = |(bus.done & bus.gnt);
    hold_hit = (HOLD_MAX != 0) && (hold_q == HOLD_LAST);
    rel      = (state_q == OWNED) && (!own_req || own_done || hold_hit);
    // Masking the current owner stops it re-winning at its own release.
    elig     = bus.req & ~bus.gnt;
    if (MODE == ARB_MODE_FIXED) begin
      start = IDW'(N - 1);
    end else if (rr_last_q == '0) begin
      start = IDW'(N - 1);
    end else begin
      start = rr_last_q - IDW'(1);
    end
  end

  rotating_msb_picker #(
    .N   (N),
    .IDW (IDW)
  ) u_picker (
    .vec   (elig),
    .start (start),
    .win   (win),
    .found (found)
  );

  // Next-state, hold counter and next registered outputs.
  always_comb begin
    state_n   = state_q;
    hold_n    = hold_q;
    rr_last_n = rr_last_q;
    gnt_n     = bus.gnt;
    valid_n   = bus.gnt_valid;
    idx_n     = bus.gnt_idx;
    timeout_n = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_n   = OWNED;
          gnt_n     = win;
          valid_n   = 1'b1;
          idx_n     = IDW'(onehot_to_idx(ARB_MAX_N'(win)));
          hold_n    = '0;
          rr_last_n = IDW'(onehot_to_idx(ARB_MAX_N'(win)));
        end
      end
      OWNED: begin
        if (rel) begin
          // Only a pure hold-limit expiry is reported as a timeout.
          timeout_n = hold_hit && own_req && !own_done;
          hold_n    = '0;
          if (found) begin
            state_n   = OWNED;
            gnt_n     = win;
            valid_n   = 1'b1;
            idx_n     = IDW'(onehot_to_idx(ARB_MAX_N'(win)));
            rr_last_n = IDW'(onehot_to_idx(ARB_MAX_N'(win)));
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            valid_n = 1'b0;
            idx_n   = '0;
          end
        end else if ((HOLD_MAX != 0) && (hold_q != HOLD_LAST)) begin
          hold_n = hold_q + HCW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        valid_n = 1'b0;
        idx_n   = '0;
        hold_n  = '0;
      end
    endcase
  end

  // State, counters and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      rr_last_q     <= '0;
      bus.gnt       <= '0;
      bus.gnt_valid <= 1'b0;
      bus.gnt_idx   <= '0;
      bus.timeout   <= 1'b0;
    end else begin
      state_q       <= state_n;
      hold_q        <= hold_n;
      rr_last_q     <= rr_last_n;
      bus.gnt       <= gnt_n;
      bus.gnt_valid <= valid_n;
      bus.gnt_idx   <= idx_n;
      bus.timeout   <= timeout_n;
    end
  end

endmodule

// File: doc/render_lock_arbiter.md
Name: render_lock_arbiter

Overview:
Parametrised N-way arbiter for render-pipeline shared resources such as the framebuffer write port and texture memory. It generalises the combinational 6-bit MSB priority picker into a registered, lockable arbiter with two modes: fixed MSB-first priority or round-robin. A grant is held until the owner signals done, the owner drops its request, or a hold timeout expires. Sits between render units and a single shared slave.

Parameters:
N, 6, number of requesters (2..32)
MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin
HOLD_MAX, 16, max cycles a grant is held before forced release; 0 = unlimited
IDW, $clog2(N), width of gnt_idx (derived, not overridable)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  N  request vector, level-sensitive
done  in  N  owner's transaction-complete pulse; only done[owner] is honoured
gnt  out  N  registered one-hot grant
gnt_valid  out  1  high when any grant is active (OR of gnt)
gnt_idx  out  IDW  binary index of owner; 0 when gnt_valid is low
timeout  out  1  one-cycle pulse, asserted in the cycle after a forced release

Behaviour:
- Reset (asynchronous, rst_n low): gnt=0, gnt_valid=0, gnt_idx=0, timeout=0, state=IDLE, hold_cnt=0, rr_last=0, so the first round-robin search starts at N-1.
- States: IDLE (no owner) and OWNED (one owner, locked).
- Arbitration point: any cycle in IDLE, or a cycle in OWNED where a release condition holds. The winner is registered, giving 1-cycle latency from req to gnt.
- Release conditions in OWNED, evaluated on the current cycle:
  - done[owner]=1
  - req[owner]=0
  - HOLD_MAX!=0 and hold_cnt==HOLD_MAX-1
- On release, the grant moves directly to the new winner next cycle with no idle gap. If no other eligible request exists, gnt goes to 0 and state goes to IDLE.
- Eligible set on release: req with the owner's bit masked. The owner may re-win only on a later arbitration point, which prevents self re-grant.
- Fixed mode: the winner is the highest set index of the eligible set.
- Round-robin mode:
  - Search order is rr_last-1 down to 0, then wraps to N-1 and continues down to rr_last.
  - rr_last updates to the new owner's index on every grant.
- hold_cnt clears on every new grant and increments each OWNED cycle. It saturates and is unused when HOLD_MAX=0.
- timeout pulses for one cycle in the cycle after a release caused only by the hold limit. If done or a req drop coincides with the limit, it counts as a normal release and timeout stays 0.
- Requests and done pulses from non-owners are ignored while OWNED.
- done for a non-owner has no effect at any time.
- gnt stays exactly one-hot or zero at all times. gnt_idx and gnt_valid are registered together with gnt.
- Reset mid-grant clears all state immediately, with no completion handshake.

Decomposition:
- Shared package render_arb_pkg holds:
  - ARB_MODE_FIXED=0 and ARB_MODE_RR=1
  - arb_state_t enum {IDLE, OWNED}
  - a function onehot_to_idx
- One natural sub-module: rotating_msb_picker (combinational). Inputs are an N-bit vector and a start index. Outputs are the one-hot winner and a found flag, scanning downward from the start with wrap. Fixed mode uses start=N-1.
- The top level holds the FSM, hold counter, rr_last register and output registers.

Test Plan:
- Fixed, N=6: req=6'b101001 from reset. Next cycle gnt=6'b100000, gnt_idx=5. Hold req → gnt unchanged for 15 more cycles. Then timeout=1, and the following cycle gnt=6'b001000.
- Fixed: owner 5 pulses done[5] with req=6'b100100 still set. Next cycle gnt=6'b000100, with no zero-grant gap.
- RR, all req=6'b111111, done pulsed every cycle by the owner. Grants cycle 5,4,3,2,1,0,5…, each index granted exactly once per 6 grants.
- RR: owner 3 drops req with req=6'b001000→6'b000000. Next cycle gnt=0, gnt_valid=0, state IDLE. A later req=6'b010001 → grant to 1, the first below rr_last=3.
- done[2] asserted while owner is 4, with req=6'b010100. gnt stays 6'b010000 and hold_cnt keeps counting.
- Assert rst_n=0 mid-grant with gnt=6'b000010. All outputs are 0 asynchronously, before the next clk edge. After release, the first RR grant starts the search from index 5.
